// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// holds one fetched instruction for the IF/ID register.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [63:0] PC,
  output logic [31:0] Instruction,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign_err
);

  localparam logic [63:0] PC_INC = 64'(PC_STEP);

  logic [63:0] pc_r;
  logic        buf_valid_r;
  logic [63:0] buf_pc_r;
  logic [31:0] buf_ins_r;
  logic        misalign_r;

  logic [63:0] pc_nxt_s;
  logic        buf_valid_nxt_s;
  logic [63:0] buf_pc_nxt_s;
  logic [31:0] buf_ins_nxt_s;
  logic        misalign_nxt_s;

  // Next-state selection: redirect beats stall beats normal fetch.
  always_comb begin
    pc_nxt_s        = pc_r;
    buf_valid_nxt_s = buf_valid_r;
    buf_pc_nxt_s    = buf_pc_r;
    buf_ins_nxt_s   = buf_ins_r;
    misalign_nxt_s  = 1'b0;
    if (branch_taken) begin
      // Low bits are forced to zero; a misaligned target is only reported.
      pc_nxt_s        = {branch_target[63:2], 2'b00};
      buf_valid_nxt_s = 1'b0;
      misalign_nxt_s  = (branch_target[1:0] != 2'b00);
    end else if (stall) begin
      pc_nxt_s        = pc_r;
      buf_valid_nxt_s = buf_valid_r;
    end else if (imem_ready) begin
      pc_nxt_s        = pc_r + PC_INC;
      buf_valid_nxt_s = 1'b1;
      buf_pc_nxt_s    = pc_r;
      buf_ins_nxt_s   = imem_rdata;
    end else begin
      // Wait state: keep the request address, emit a bubble downstream.
      pc_nxt_s        = pc_r;
      buf_valid_nxt_s = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r        <= RESET_PC;
      buf_valid_r <= 1'b0;
      buf_pc_r    <= 64'h0;
      buf_ins_r   <= 32'h0;
      misalign_r  <= 1'b0;
    end else begin
      pc_r        <= pc_nxt_s;
      buf_valid_r <= buf_valid_nxt_s;
      buf_pc_r    <= buf_pc_nxt_s;
      buf_ins_r   <= buf_ins_nxt_s;
      misalign_r  <= misalign_nxt_s;
    end
  end

  // Request and flush are combinational so a redirect suppresses fetch in-cycle.
  always_comb begin
    imem_req  = ~reset & ~stall & ~branch_taken;
    imem_addr = pc_r;
    flush     = branch_taken | (~buf_valid_r & ~stall);
  end

  assign PC           = buf_pc_r;
  assign Instruction  = buf_ins_r;
  assign fetch_valid  = buf_valid_r;
  assign misalign_err = misalign_r;

endmodule
